if_stage: RTL and testbench

- Fetch stage directly downstream of the pre-IF stage.
- Accepts pre-IF requests, each carrying PC, exception info, a wrong-path flag and an "ICache access issued" flag. Pairs each request with its in-order ICache read data.
- Buffers results in a small in-order queue and presents them to the decode stage with a valid/allowin handshake.
- Discards wrong-path entries, and cancels in-flight ICache returns on flush.

---
 rtl/if_stage_pkg.sv | 32 +++
 rtl/fetch_queue.sv | 95 +++++++++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, bus field offsets and queue entry type for the fetch stage.
// Pure declarations: no latency, no flow control.
package if_stage_pkg;

    localparam int PS_TO_FS_BUS_WD = 40;
    localparam int FS_TO_DS_BUS_WD = 70;

    localparam int PS_INST_VALID_BIT = 39;
    localparam int PS_BDD_BIT        = 38;
    localparam int PS_PC_LSB         = 6;
    localparam int PS_EX_BIT         = 5;
    localparam int FS_INST_LSB       = 38;

    localparam int FQ_DEPTH = 4;

    localparam logic [4:0] NO_EX    = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef struct packed {
        logic        vld;
        logic        data_ok;
        logic [31:0] pc;
        logic        ex;
        logic [4:0]  exctype;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_bus(input fq_entry_t e);
        return {e.inst, e.pc, e.ex, e.exctype};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue with per-entry data_ok and an oldest-pending fill port; 1-cycle enq-to-head.
// No internal backpressure: caller must not enqueue when full; clear empties the queue next cycle.
module fetch_queue
    import if_stage_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enq_vld,
    input  fq_entry_t        enq_entry,
    input  logic             deq,
    input  logic             fill_vld,
    input  logic [31:0]      fill_inst,
    output logic             fill_hit,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             full,
    output fq_entry_t        head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]      fill_idx, scan_idx;
    logic [CNT_W-1:0]      count_q, count_d;

    assign head = ent_q[head_q];
    assign full = (count_q == CNT_W'(DEPTH));

    // Walk from youngest to oldest so the last match is the oldest pending entry.
    always_comb begin
        fill_hit    = 1'b0;
        fill_idx    = '0;
        scan_idx    = '0;
        pending_cnt = '0;
        for (int j = 0; j < DEPTH; j++) begin
            pending_cnt = pending_cnt + CNT_W'(ent_q[j].vld & ~ent_q[j].data_ok);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = head_q + PTR_W'(i);
            if (ent_q[scan_idx].vld && !ent_q[scan_idx].data_ok) begin
                fill_hit = 1'b1;
                fill_idx = scan_idx;
            end
        end
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            for (int j = 0; j < DEPTH; j++) begin
                ent_d[j].vld = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (fill_vld && fill_hit) begin
                ent_d[fill_idx].inst    = fill_inst;
                ent_d[fill_idx].data_ok = 1'b1;
            end
            if (deq) begin
                ent_d[head_q].vld = 1'b0;
                head_d            = head_q + PTR_W'(1);
            end
            if (enq_vld) begin
                ent_d[tail_q]     = enq_entry;
                ent_d[tail_q].vld = 1'b1;
                tail_d            = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq_vld) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: pairs pre-IF requests with in-order ICache data; >=1 cycle request-to-decode.
// fs_allowin drops only when the queue is full (no ds_allowin feed-through); flush cancels pending returns.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ps_to_fs_valid,
    input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
    output logic                       fs_allowin,
    input  logic                       icache_rdata_ok,
    input  logic [31:0]                icache_rdata,
    input  logic                       flush,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             ps_inst_valid, ps_bdd, accept;
    logic             enq_vld, fill_vld, fill_hit, q_full, deq;
    logic             cancel_hit, ret_drop;
    logic [CNT_W-1:0] pending_cnt, cancel_q, cancel_d;
    logic [CNT_W:0]   cancel_sum;
    fq_entry_t        enq_entry, head;

    assign ps_inst_valid = ps_to_fs_bus[PS_INST_VALID_BIT];
    assign ps_bdd        = ps_to_fs_bus[PS_BDD_BIT];

    assign fs_allowin = ~q_full | flush;
    assign accept     = ps_to_fs_valid & fs_allowin & ~flush;
    assign enq_vld    = accept & ~ps_bdd;

    always_comb begin
        enq_entry         = '0;
        enq_entry.vld     = 1'b1;
        enq_entry.data_ok = ~ps_inst_valid;
        enq_entry.pc      = ps_to_fs_bus[PS_PC_LSB +: 32];
        enq_entry.ex      = ps_to_fs_bus[PS_EX_BIT];
        enq_entry.exctype = ps_to_fs_bus[4:0];
    end

    // Returns owed to cancelled requests are ahead of any live entry's data in ICache order.
    assign cancel_hit = icache_rdata_ok & (cancel_q != '0);
    assign fill_vld   = icache_rdata_ok & ~cancel_hit & ~flush;
    assign ret_drop   = cancel_hit | (icache_rdata_ok & fill_hit);

    assign fs_to_ds_valid = head.vld & head.data_ok & ~flush;
    assign deq            = fs_to_ds_valid & ds_allowin;
    assign fs_to_ds_bus   = head.vld ? pack_fs_bus(head) : '0;

    always_comb begin
        cancel_sum = {1'b0, cancel_q};
        if (flush) begin
            cancel_sum = cancel_sum + {1'b0, pending_cnt} - (CNT_W+1)'(ret_drop);
        end else begin
            cancel_sum = cancel_sum + (CNT_W+1)'(accept & ps_bdd & ps_inst_valid)
                                    - (CNT_W+1)'(cancel_hit);
        end
        cancel_d = (cancel_sum > (CNT_W+1)'(CNT_MAX)) ? CNT_W'(CNT_MAX) : cancel_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cancel_q <= '0;
        end else begin
            cancel_q <= cancel_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_queue (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .enq_vld     (enq_vld),
        .enq_entry   (enq_entry),
        .deq         (deq),
        .fill_vld    (fill_vld),
        .fill_inst   (icache_rdata),
        .fill_hit    (fill_hit),
        .pending_cnt (pending_cnt),
        .full        (q_full),
        .head        (head)
    );

endmodule

// File: tb/tb_if_stage.sv
// Fetch stage bench: directed scenarios with literal expectations plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_if_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_to_fs_valid;
    logic [39:0] ps_to_fs_bus;
    logic        fs_allowin;
    logic        icache_rdata_ok;
    logic [31:0] icache_rdata;
    logic        flush;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [69:0] fs_to_ds_bus;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic        ex;
        logic [4:0]  exc;
        logic [31:0] inst;
        bit          ok;
    } ent_t;

    ent_t mq[$];
    int   mcancel     = 0;
    int   outstanding = 0;

    if_stage #(.DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .ps_to_fs_valid  (ps_to_fs_valid),
        .ps_to_fs_bus    (ps_to_fs_bus),
        .fs_allowin      (fs_allowin),
        .icache_rdata_ok (icache_rdata_ok),
        .icache_rdata    (icache_rdata),
        .flush           (flush),
        .ds_allowin      (ds_allowin),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mkps(input bit iv, input bit bdd, input logic [31:0] pc,
                                         input bit ex, input logic [4:0] exc);
        return {iv, bdd, pc, ex, exc};
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcancel     = 0;
        outstanding = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit pv, input logic [39:0] pb, input bit rok,
                        input logic [31:0] rd, input bit fl, input bit dsa);
        ent_t        e;
        int          pend;
        bit          exp_vld, exp_allow, found;
        logic [69:0] exp_bus;
        @(negedge clk);
        ps_to_fs_valid  = pv;
        ps_to_fs_bus    = pb;
        icache_rdata_ok = rok;
        icache_rdata    = rd;
        flush           = fl;
        ds_allowin      = dsa;
        #1;
        exp_allow = (mq.size() < DEPTH) || fl;
        exp_vld   = (mq.size() > 0) && mq[0].ok && !fl;
        exp_bus   = (mq.size() > 0) ? {mq[0].inst, mq[0].pc, mq[0].ex, mq[0].exc} : 70'h0;
        chk("allowin", {69'h0, fs_allowin}, {69'h0, exp_allow});
        chk("valid", {69'h0, fs_to_ds_valid}, {69'h0, exp_vld});
        chk("bus", fs_to_ds_bus, exp_bus);

        if (pv && exp_allow && !fl && pb[39]) outstanding++;
        if (rok) outstanding--;
        if (fl) begin
            pend = 0;
            foreach (mq[i]) if (!mq[i].ok) pend++;
            mcancel = mcancel + pend - ((rok && (mcancel > 0 || pend > 0)) ? 1 : 0);
            mq.delete();
        end else begin
            if (rok) begin
                if (mcancel > 0) begin
                    mcancel--;
                end else begin
                    found = 0;
                    foreach (mq[i]) begin
                        if (!found && !mq[i].ok) begin
                            mq[i].inst = rd;
                            mq[i].ok   = 1;
                            found      = 1;
                        end
                    end
                    if (!found) begin
                        nfail++;
                        $display("FAIL stim_protocol: return with no pending request");
                    end
                end
            end
            if (exp_vld && dsa) void'(mq.pop_front());
            if (pv && exp_allow) begin
                if (pb[38]) begin
                    if (pb[39]) mcancel++;
                end else begin
                    e.pc   = pb[37:6];
                    e.ex   = pb[5];
                    e.exc  = pb[4:0];
                    e.inst = 32'h0;
                    e.ok   = !pb[39];
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input bit dsa);
        step(0, 40'h0, 0, 32'h0, 0, dsa);
    endtask

    task automatic scen_single();
        step(1, mkps(1, 0, 32'hBFC00000, 0, 5'h0), 0, 0, 0, 0);
        idle(0);
        step(0, 40'h0, 1, 32'h24080001, 0, 0);
        chk("s1_not_yet", {69'h0, fs_to_ds_valid}, 70'h0);
        idle(1);
        chk("s1_valid", {69'h0, fs_to_ds_valid}, 70'h1);
        chk("s1_bus", fs_to_ds_bus, {32'h24080001, 32'hBFC00000, 1'b0, 5'h0});
        idle(0);
        chk("s1_popped", {69'h0, fs_to_ds_valid}, 70'h0);
    endtask

    int          r_pv, r_rok, r_fl, r_dsa;
    logic [39:0] r_bus;

    initial begin
        reset = 1'b0;
        ps_to_fs_valid = 0; ps_to_fs_bus = '0; icache_rdata_ok = 0;
        icache_rdata = '0; flush = 0; ds_allowin = 0;
        #12;
        chk("rst_valid", {69'h0, fs_to_ds_valid}, 70'h0);
        chk("rst_bus", fs_to_ds_bus, 70'h0);
        chk("rst_allowin", {69'h0, fs_allowin}, 70'h1);
        @(negedge clk);
        reset = 1'b1;

        scen_single();

        // Fill to full with decode stalled, then drain in PC order.
        for (int k = 0; k < 4; k++) step(1, mkps(1, 0, 32'h00001000 + 4 * k, 0, 5'h0), 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 40'h0, 1, 32'hC0DE0000 + k, 0, 0);
            if (k == 0) chk("s2_full", {69'h0, fs_allowin}, 70'h0);
        end
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("s2_pop_vld", {69'h0, fs_to_ds_valid}, 70'h1);
            chk("s2_pop_pc", {38'h0, fs_to_ds_bus[37:6]}, {38'h0, 32'h00001000 + 4 * k});
            chk("s2_pop_inst", {38'h0, fs_to_ds_bus[69:38]}, {38'h0, 32'hC0DE0000 + k});
            if (k == 0) chk("s2_no_comb_allowin", {69'h0, fs_allowin}, 70'h0);
        end
        idle(0);
        chk("s2_allowin_back", {69'h0, fs_allowin}, 70'h1);

        // Wrong-path request consumes the first return.
        step(1, mkps(1, 1, 32'h80000010, 0, 5'h0), 0, 0, 0, 0);
        step(1, mkps(1, 0, 32'h80000040, 0, 5'h0), 0, 0, 0, 0);
        step(0, 40'h0, 1, 32'hAAAA0001, 0, 0);
        step(0, 40'h0, 1, 32'hBBBB0002, 0, 0);
        idle(1);
        chk("s3_bus", fs_to_ds_bus, {32'hBBBB0002, 32'h80000040, 1'b0, 5'h0});

        // Flush with two returns outstanding.
        step(1, mkps(1, 0, 32'h80001000, 0, 5'h0), 0, 0, 0, 0);
        step(1, mkps(1, 0, 32'h80001004, 0, 5'h0), 0, 0, 0, 0);
        step(0, 40'h0, 0, 0, 1, 1);
        chk("s4_flush_valid", {69'h0, fs_to_ds_valid}, 70'h0);
        idle(0);
        chk("s4_empty_bus", fs_to_ds_bus, 70'h0);
        step(1, mkps(1, 0, 32'hBFC00380, 0, 5'h0), 1, 32'hDEAD0001, 0, 0);
        step(0, 40'h0, 1, 32'hDEAD0002, 0, 0);
        step(0, 40'h0, 1, 32'h3C1A0003, 0, 0);
        idle(1);
        chk("s4_bus", fs_to_ds_bus, {32'h3C1A0003, 32'hBFC00380, 1'b0, 5'h0});

        // Exception slot with no ICache access.
        step(1, mkps(0, 0, 32'h80000002, 1, 5'h04), 0, 0, 0, 0);
        idle(1);
        chk("s5_valid", {69'h0, fs_to_ds_valid}, 70'h1);
        chk("s5_bus", fs_to_ds_bus, {32'h0, 32'h80000002, 1'b1, 5'h04});

        // Async reset with three entries and one cancelled return in flight.
        step(1, mkps(1, 1, 32'h80000100, 0, 5'h0), 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, mkps(1, 0, 32'h80000104 + 4 * k, 0, 5'h0), 0, 0, 0, 0);
        idle(0);
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_valid", {69'h0, fs_to_ds_valid}, 70'h0);
        chk("s6_rst_bus", fs_to_ds_bus, 70'h0);
        chk("s6_rst_allowin", {69'h0, fs_allowin}, 70'h1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        scen_single();

        // Randomized traffic; returns only for accesses issued in earlier cycles.
        for (int c = 0; c < 4000; c++) begin
            r_pv  = ($urandom_range(0, 1) == 1);
            r_bus = mkps($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15, $urandom,
                         $urandom_range(0, 9) == 0, 5'($urandom_range(0, 31)));
            r_rok = (outstanding > 0) && ($urandom_range(0, 1) == 1);
            r_fl  = ($urandom_range(0, 99) < 4);
            r_dsa = ($urandom_range(0, 9) < 6);
            step(r_pv[0], r_bus, r_rok[0], $urandom, r_fl[0], r_dsa[0]);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
